// File: rtl/result_packer_pkg.sv
// result_packer_pkg: shared line geometry and the default line record used by the line FIFO.
//   LINE_BYTES / LINE_W : bytes and bits per result line
//   line_t              : {addr, data, strb} record for the default 16-bit byte address
//   byte_bit            : one-hot strobe for a byte index within a line
package result_packer_pkg;
    localparam int LINE_BYTES  = 16;
    localparam int LINE_W      = 128;
    localparam int LINE_ADDR_W = 12;
    typedef struct packed {
        logic [LINE_ADDR_W-1:0] addr;
        logic [LINE_W-1:0]      data;
        logic [LINE_BYTES-1:0]  strb;
    } line_t;
    function automatic logic [LINE_BYTES-1:0] byte_bit(input logic [3:0] b);
        return LINE_BYTES'(1) << b;
    endfunction
endpackage

// File: rtl/result_packer_if.sv
// result_packer_if: valid/ready line-write port toward the result SRAM.
//   valid/addr/data/strb : driven by the packer (master)
//   ready                : driven by the memory side (slave)
interface result_packer_if #(parameter int ADDR_W = 16);
    logic              valid;
    logic              ready;
    logic [ADDR_W-5:0] addr;
    logic [127:0]      data;
    logic [15:0]       strb;
    modport master (output valid, addr, data, strb, input ready);
    modport slave  (input valid, addr, data, strb, output ready);
endinterface

// File: rtl/result_packer_line_fifo.sv
// line_fifo: synchronous FIFO of line records with full/empty flags.
//   clk, rst (sync, active-low), push/din write side, pop/dout read side,
//   full/empty status. dout is the head entry, forced to zero while empty.
//   A push while full is accepted only when a pop happens in the same cycle.
module line_fifo
    import result_packer_pkg::*;
#(
    parameter type T     = line_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic wr_en, rd_en;
    always_comb begin
        empty = wr_q == rd_q;
        full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        rd_en = pop && !empty;
        wr_en = push && (!full || rd_en);
        wr_d  = wr_q + (AW+1)'(wr_en);
        rd_d  = rd_q + (AW+1)'(rd_en);
        dout  = empty ? '0 : mem[rd_q[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/result_packer.sv
// result_packer: packs conv_pool byte results into 128-bit strobed lines and queues them to the result SRAM.
//   clk, rst (sync, active-low)
//   in_we/in_addr/in_y : non-stallable byte result stream
//   flush              : pulse, emits the partial line on the next idle cycle
//   out                : valid/ready line-write port (master)
//   busy, overflow (sticky line drop), line_count (accepted beats, wrapping)
module result_packer
    import result_packer_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_we,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [7:0]           in_y,
    input  logic                 flush,
    result_packer_if.master      out,
    output logic                 busy,
    output logic                 overflow,
    output logic [15:0]          line_count
);
    typedef struct packed {
        logic [ADDR_W-5:0]     addr;
        logic [LINE_W-1:0]     data;
        logic [LINE_BYTES-1:0] strb;
    } pline_t;
    logic                  line_valid_q, line_valid_d, flush_pending_q, flush_pending_d;
    logic                  overflow_q, overflow_d, push, pop, fresh, full, empty;
    logic [ADDR_W-5:0]     line_addr_q, line_addr_d, a;
    logic [LINE_W-1:0]     data_q, data_d;
    logic [LINE_BYTES-1:0] strb_q, strb_d;
    logic [15:0]           line_count_q, line_count_d;
    logic [3:0]            b;
    pline_t                push_line, head;
    assign a = in_addr[ADDR_W-1:4];
    assign b = in_addr[3:0];
    always_comb begin
        line_valid_d    = line_valid_q;
        line_addr_d     = line_addr_q;
        data_d          = data_q;
        strb_d          = strb_q;
        flush_pending_d = flush_pending_q | flush;
        fresh           = 1'b1;
        push            = 1'b0;
        push_line       = '{line_addr_q, data_q, strb_q};
        if (in_we) begin
            // A write to a different line evicts the current one before starting afresh.
            fresh        = !line_valid_q || a != line_addr_q;
            push         = line_valid_q && a != line_addr_q;
            line_addr_d  = a;
            data_d       = fresh ? '0 : data_q;
            data_d[{b, 3'b000} +: 8] = in_y;
            strb_d       = (fresh ? '0 : strb_q) | byte_bit(b);
            line_valid_d = ~&strb_d;
            // Completion only happens on a merge, so it never collides with an eviction push.
            if (&strb_d) begin
                push      = 1'b1;
                push_line = '{line_addr_d, data_d, strb_d};
            end
        end else if (flush_pending_q) begin
            flush_pending_d = flush;
            push            = line_valid_q;
            line_valid_d    = 1'b0;
        end
        pop          = out.valid & out.ready;
        overflow_d   = overflow_q | (push & full & !pop);
        line_count_d = line_count_q + 16'(pop);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            line_valid_q    <= 1'b0;
            line_addr_q     <= '0;
            data_q          <= '0;
            strb_q          <= '0;
            flush_pending_q <= 1'b0;
            overflow_q      <= 1'b0;
            line_count_q    <= '0;
        end else begin
            line_valid_q    <= line_valid_d;
            line_addr_q     <= line_addr_d;
            data_q          <= data_d;
            strb_q          <= strb_d;
            flush_pending_q <= flush_pending_d;
            overflow_q      <= overflow_d;
            line_count_q    <= line_count_d;
        end
    end
    line_fifo #(.T(pline_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_line),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    assign out.valid  = !empty;
    assign out.addr   = head.addr;
    assign out.data   = head.data;
    assign out.strb   = head.strb;
    assign busy       = line_valid_q | !empty | flush_pending_q;
    assign overflow   = overflow_q;
    assign line_count = line_count_q;
endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: directed vector table plus hand-written backpressure, overflow and reset sequences.
module tb_result_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_we = 1'b0;
    logic [15:0] in_addr = '0;
    logic [7:0]  in_y = '0;
    logic        flush = 1'b0;
    logic        busy, overflow;
    logic [15:0] line_count;
    int          errors = 0;
    int          checks = 0;

    result_packer_if #(.ADDR_W(16)) out_if ();

    result_packer #(.ADDR_W(16), .FIFO_DEPTH(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_we      (in_we),
        .in_addr    (in_addr),
        .in_y       (in_y),
        .flush      (flush),
        .out        (out_if),
        .busy       (busy),
        .overflow   (overflow),
        .line_count (line_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [15:0]  addr;
        logic [7:0]   y;
        logic         fl;
        logic         rdy;
        logic         ev;
        logic [11:0]  ea;
        logic [127:0] ed;
        logic [15:0]  es;
        logic         eb;
        logic [15:0]  elc;
    } vec_t;
    vec_t vq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [15:0] addr, input logic [7:0] y, input logic fl,
                       input logic rdy, input logic ev, input logic [11:0] ea, input logic [127:0] ed,
                       input logic [15:0] es, input logic eb, input logic [15:0] elc);
        vec_t v;
        v = '{we, addr, y, fl, rdy, ev, ea, ed, es, eb, elc};
        vq.push_back(v);
    endtask

    function automatic logic [127:0] line_data(input int l);
        logic [127:0] d;
        d = '0;
        for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(l * 16 + k);
        return d;
    endfunction

    task automatic write_line(input int l, input logic last_rdy);
        for (int i = 0; i < 16; i++) begin
            in_we   = 1'b1;
            in_addr = 16'(l * 16 + i);
            in_y    = 8'(l * 16 + i);
            if (i == 15) out_if.ready = last_rdy;
            tick();
        end
        in_we = 1'b0;
    endtask

    task automatic do_reset();
        in_we = 1'b0;
        flush = 1'b0;
        rst   = 1'b0;
        tick();
        rst   = 1'b1;
    endtask

    task automatic chk_head(input string nm, input int l);
        chk({nm, "_valid"}, 128'(out_if.valid), 128'(1));
        chk({nm, "_addr"}, 128'(out_if.addr), 128'(l));
        chk({nm, "_data"}, out_if.data, line_data(l));
        chk({nm, "_strb"}, 128'(out_if.strb), 128'hFFFF);
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_valid"}, 128'(out_if.valid), 128'(0));
        chk({nm, "_addr"}, 128'(out_if.addr), 128'(0));
        chk({nm, "_data"}, out_if.data, 128'(0));
        chk({nm, "_strb"}, 128'(out_if.strb), 128'(0));
        chk({nm, "_busy"}, 128'(busy), 128'(0));
        chk({nm, "_overflow"}, 128'(overflow), 128'(0));
        chk({nm, "_line_count"}, 128'(line_count), 128'(0));
    endtask

    initial begin
        out_if.ready = 1'b1;
        for (int i = 0; i < 16; i++)
            add(1, 16'(i), 8'(i), 0, 1, i == 15, 12'h0,
                128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF, 1, 16'd0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'd1);
        add(1, 16'h25, 8'hAA, 0, 1, 0, 0, 0, 0, 1, 16'd1);
        add(1, 16'h27, 8'hBB, 0, 1, 0, 0, 0, 0, 1, 16'd1);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 16'd1);
        add(0, 0, 0, 0, 1, 1, 12'h2, 128'h0000_0000_0000_0000_BB00_AA00_0000_0000, 16'h00A0, 1, 16'd1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'd2);
        add(1, 16'h10, 8'h11, 0, 1, 0, 0, 0, 0, 1, 16'd2);
        add(1, 16'h10, 8'h22, 0, 1, 0, 0, 0, 0, 1, 16'd2);
        add(1, 16'h35, 8'h33, 1, 1, 1, 12'h1, 128'h22, 16'h0001, 1, 16'd2);
        add(0, 0, 0, 0, 1, 1, 12'h3, 128'h0000_0000_0000_0000_0000_3300_0000_0000, 16'h0020, 1, 16'd3);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'd4);

        tick();
        tick();
        chk_idle_zero("reset");
        rst = 1'b1;

        foreach (vq[n]) begin
            in_we        = vq[n].we;
            in_addr      = vq[n].addr;
            in_y         = vq[n].y;
            flush        = vq[n].fl;
            out_if.ready = vq[n].rdy;
            tick();
            chk($sformatf("vec%0d_valid", n), 128'(out_if.valid), 128'(vq[n].ev));
            chk($sformatf("vec%0d_busy", n), 128'(busy), 128'(vq[n].eb));
            chk($sformatf("vec%0d_line_count", n), 128'(line_count), 128'(vq[n].elc));
            if (vq[n].ev) begin
                chk($sformatf("vec%0d_addr", n), 128'(out_if.addr), 128'(vq[n].ea));
                chk($sformatf("vec%0d_data", n), out_if.data, vq[n].ed);
                chk($sformatf("vec%0d_strb", n), 128'(out_if.strb), 128'(vq[n].es));
            end
        end
        in_we = 1'b0;
        flush = 1'b0;

        do_reset();
        out_if.ready = 1'b0;
        for (int l = 4; l <= 8; l++) begin
            write_line(l, 1'b0);
            chk($sformatf("ovf_after_line%0d", l), 128'(overflow), 128'(l == 8));
            chk_head($sformatf("ovf_hold_line%0d", l), 4);
        end
        tick();
        tick();
        chk_head("ovf_stable", 4);
        for (int k = 0; k < 4; k++) begin
            chk_head($sformatf("drain%0d", k), 4 + k);
            out_if.ready = 1'b1;
            tick();
        end
        chk("drain_empty", 128'(out_if.valid), 128'(0));
        chk("drain_line_count", 128'(line_count), 128'(4));
        chk("drain_overflow_sticky", 128'(overflow), 128'(1));

        do_reset();
        out_if.ready = 1'b0;
        for (int l = 9; l <= 12; l++) write_line(l, 1'b0);
        chk_head("full_head", 9);
        write_line(13, 1'b1);
        chk("fullpp_overflow", 128'(overflow), 128'(0));
        for (int l = 10; l <= 13; l++) begin
            chk_head($sformatf("fullpp%0d", l), l);
            tick();
        end
        chk("fullpp_empty", 128'(out_if.valid), 128'(0));
        chk("fullpp_line_count", 128'(line_count), 128'(5));
        chk("fullpp_overflow_end", 128'(overflow), 128'(0));

        out_if.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_we   = 1'b1;
            in_addr = 16'(16'h20 + i);
            in_y    = 8'(i + 1);
            tick();
        end
        in_we = 1'b0;
        chk("midline_busy", 128'(busy), 128'(1));
        rst = 1'b0;
        tick();
        chk_idle_zero("midreset");
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_reset_flush_valid%0d", i), 128'(out_if.valid), 128'(0));
        end
        chk("post_reset_flush_busy", 128'(busy), 128'(0));
        chk("post_reset_flush_line_count", 128'(line_count), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
